arcade_cfg_inputs: RTL and testbench
====================================

// Module: arcade_cfg_inputs
// PURPOSE
// - Parametrised config/input front-end between hps_io / DB9-DB15 decoders and an arcade core.
// - Captures the game-select byte and N DIP banks from the ioctl stream into shadow buffers, committed
//   atomically at download end; muxes per-player USB/DB joysticks; shapes coin inputs into fixed-length pulses.
// - Generalises the fixed 2-player, 8-bank, level-coin handling of earlier cores.
// PARAMETERS
// NUM_PLAYERS    2    players muxed; each player has a 16-bit joystick word
// NUM_DIP_BANKS  8    DIP bytes kept; 1..32
// DIP_INDEX      254  ioctl_index carrying DIP bytes
// MOD_INDEX      1    ioctl_index carrying the game-select byte (address 0 only)
// NUM_COINS      2    coin channels
// COIN_PULSE     4    coin pulse high time, in tick periods; >=1
// COIN_GAP       4    minimum low time after a pulse, in tick periods; >=1
// PORTS
// clk_sys         in   1        system clock (same domain as hps_io clk_sys)
// RESET_L         in   1        asynchronous active-low reset
// ioctl_download  in   1        download in progress
// ioctl_wr        in   1        one-cycle byte strobe
// ioctl_index     in   8        download index
// ioctl_addr      in   25       byte address within the download
// ioctl_dout      in   8        byte data
// tick            in   1        one-cycle timing enable for coin shaping (e.g. 1 kHz)
// joy_usb         in   16*NP    USB joysticks, player p at [16p+:16]
// joy_db          in   16*NP    DB9/DB15 joysticks, same layout
// db_ena          in   NP       per-player: 1 selects joy_db
// coin_raw        in   NUM_COINS  active-high level coin buttons
// mod             out  8        committed game-select byte
// mod_valid       out  1        a MOD download has been committed
// dip             out  8*NB     committed DIP banks, bank b at [8b+:8]
// dip_valid       out  1        a DIP download has been committed
// joy_out         out  16*NP    selected joystick per player
// joy_any         out  16       OR of all joy_out words
// coin_out        out  NUM_COINS  shaped active-high coin pulses
// BEHAVIOUR
// - Reset (async, RESET_L=0): mod=0, mod_valid=0, dip=0, dip_valid=0, shadows=0, joy_out=0, joy_any=0,
//   coin_out=0, all coin FSMs IDLE, pending=0. Outputs registered; deassertion takes effect next edge.
// - Capture: on ioctl_wr && ioctl_download:
//   - index==DIP_INDEX && addr<NB -> dip_shadow[addr]<=dout; addr>=NB ignored.
//   - index==MOD_INDEX && addr==0 -> mod_shadow<=dout.
//   - Any capture sets a per-target dirty flag.
// - Commit: on falling edge of ioctl_download (registered previous value), every dirty shadow is copied
//   to its output, the matching *_valid is set, and the dirty flag is cleared. dip/mod change in exactly
//   one cycle: the cycle after the edge is sampled. Outputs never show a partial set.
// - A download of another index commits nothing. A new download restarts dirty tracking. Unwritten banks
//   keep their previous shadow contents. Reset mid-download discards the shadows and commits nothing.
// - ioctl_wr while ioctl_download=0 is ignored.
// - Joystick: joy_out[p] <= db_ena[p] ? joy_db[p] : joy_usb[p]; joy_any <= OR over players of the mux.
//   Both have 1-cycle latency and no tick dependency.
// - Coin channel: rise = coin_raw & ~coin_raw_q. coin_raw is sampled every clk, and rise is detected
//   every clk.
//   - IDLE: on rise or pending>0 -> PULSE, cnt=0, pending-- if consumed from queue.
//   - PULSE: coin_out=1; on tick cnt++; when cnt==COIN_PULSE-1 && tick -> GAP, cnt=0.
//   - GAP: coin_out=0; on tick cnt++; when cnt==COIN_GAP-1 && tick -> IDLE.
//   - A rise in PULSE/GAP increments pending (2-bit, saturates at 3; further rises are dropped).
//   - A rise coincident with leaving GAP is queued, never lost.
//   - coin_out is a registered function of state.
// STRUCTURE
// - Package arcade_cfg_pkg: coin_state_t enum {IDLE,PULSE,GAP}, JOY_W=16, IOCTL_ADDR_W=25.
// - Sub-module coin_shaper (one channel: FSM + counter + pending), generated NUM_COINS times.
// - Capture/commit logic and joystick mux stay in the top module.
// TESTING
// 1. DIP index 254, write addr0..7=0x11..0x88, drop download -> dip unchanged until commit cycle,
//    then dip=0x8877..11 and dip_valid=1.
// 2. NB=8, DIP writes to addr 8 and 9 during download -> dip unchanged by them.
//    Index 3 download -> no commit, and mod/dip are stable.
// 3. RESET_L low mid-DIP-download after 3 bytes -> dip=0 and dip_valid=0 after reset.
//    Subsequent full download commits correctly.
// 4. COIN_PULSE=4, COIN_GAP=4, tick every 10 clk, one coin_raw rise -> coin_out high exactly 4 ticks,
//    then low 4 ticks or more; one pulse total.
// 5. Five coin_raw rises during one PULSE -> exactly 4 pulses out (1 + 3 saturated pending), with each
//    gap >= COIN_GAP.
// 6. db_ena=2'b01, joy_db[0]=0x0010, joy_usb[1]=0x0200 -> joy_out={0x0200,0x0010} and joy_any=0x0210,
//    1 clk after inputs.

Source files
------------

// File: rtl/arcade_cfg_pkg.sv
// Shared types and widths for the arcade configuration/input front-end.
package arcade_cfg_pkg;
  localparam int unsigned JOY_W        = 16;
  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned IOCTL_IDX_W  = 8;
  localparam int unsigned PEND_W       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;
endpackage

// File: rtl/arcade_cfg_inputs_coin_shaper.sv
// One coin channel: turns level coin presses into fixed-length pulses separated by a
// minimum gap, queueing up to three presses that arrive while a pulse is in flight.
module coin_shaper
  import arcade_cfg_pkg::*;
#(
  parameter int unsigned COIN_PULSE = 4,
  parameter int unsigned COIN_GAP   = 4
) (
  input  logic clk_sys,
  input  logic RESET_L,
  input  logic tick,
  input  logic coin_raw,
  output logic coin_out
);
  localparam int unsigned CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP - 1);

  coin_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              raw_q;
  logic              coin_out_q;
  logic              rise;

  assign rise     = coin_raw & ~raw_q;
  assign coin_out = coin_out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else if (pend_q != '0) begin
          state_d = PULSE;
          cnt_d   = '0;
          pend_d  = pend_q - PEND_W'(1);
        end
      end
      PULSE: begin
        if (tick) begin
          if (cnt_q == PULSE_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Presses arriving while busy (including the cycle GAP ends) are queued, saturating at 3.
    if (state_q != IDLE && rise && pend_q != '1) begin
      pend_d = pend_q + PEND_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      raw_q      <= 1'b0;
      coin_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      raw_q      <= coin_raw;
      coin_out_q <= (state_d == PULSE);
    end
  end
endmodule

// File: rtl/arcade_cfg_inputs.sv
// Config/input front-end: shadows DIP and game-select bytes from the ioctl stream and commits
// them atomically when the download ends; muxes per-player joysticks; shapes coin pulses.
module arcade_cfg_inputs
  import arcade_cfg_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_DIP_BANKS = 8,
  parameter int unsigned DIP_INDEX     = 254,
  parameter int unsigned MOD_INDEX     = 1,
  parameter int unsigned NUM_COINS     = 2,
  parameter int unsigned COIN_PULSE    = 4,
  parameter int unsigned COIN_GAP      = 4
) (
  input  logic                          clk_sys,
  input  logic                          RESET_L,
  input  logic                          ioctl_download,
  input  logic                          ioctl_wr,
  input  logic [IOCTL_IDX_W-1:0]        ioctl_index,
  input  logic [IOCTL_ADDR_W-1:0]       ioctl_addr,
  input  logic [7:0]                    ioctl_dout,
  input  logic                          tick,
  input  logic [JOY_W*NUM_PLAYERS-1:0]  joy_usb,
  input  logic [JOY_W*NUM_PLAYERS-1:0]  joy_db,
  input  logic [NUM_PLAYERS-1:0]        db_ena,
  input  logic [NUM_COINS-1:0]          coin_raw,
  output logic [7:0]                    mod,
  output logic                          mod_valid,
  output logic [8*NUM_DIP_BANKS-1:0]    dip,
  output logic                          dip_valid,
  output logic [JOY_W*NUM_PLAYERS-1:0]  joy_out,
  output logic [JOY_W-1:0]              joy_any,
  output logic [NUM_COINS-1:0]          coin_out
);
  localparam int unsigned DIP_W = 8 * NUM_DIP_BANKS;
  localparam int unsigned JBW   = JOY_W * NUM_PLAYERS;

  logic [DIP_W-1:0] dip_shadow_q, dip_shadow_d, dip_q, dip_d;
  logic [7:0]       mod_shadow_q, mod_shadow_d, mod_q, mod_d;
  logic             dip_dirty_q, dip_dirty_d, mod_dirty_q, mod_dirty_d;
  logic             dip_valid_q, dip_valid_d, mod_valid_q, mod_valid_d;
  logic             dl_q;
  logic             wr_en, dl_rise, dl_fall;
  logic [JBW-1:0]   joy_q, joy_d;
  logic [JOY_W-1:0] joy_any_q, joy_any_d;

  assign wr_en   = ioctl_wr & ioctl_download;
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = dl_q & ~ioctl_download;

  // Shadow capture during a download, then copy dirty shadows out on its falling edge.
  always_comb begin
    dip_shadow_d = dip_shadow_q;
    mod_shadow_d = mod_shadow_q;
    dip_dirty_d  = dip_dirty_q;
    mod_dirty_d  = mod_dirty_q;
    dip_d        = dip_q;
    mod_d        = mod_q;
    dip_valid_d  = dip_valid_q;
    mod_valid_d  = mod_valid_q;
    if (dl_rise) begin
      dip_dirty_d = 1'b0;
      mod_dirty_d = 1'b0;
    end
    if (wr_en && ioctl_index == IOCTL_IDX_W'(DIP_INDEX)) begin
      for (int b = 0; b < int'(NUM_DIP_BANKS); b++) begin
        if (ioctl_addr == IOCTL_ADDR_W'(b)) begin
          dip_shadow_d[8*b +: 8] = ioctl_dout;
          dip_dirty_d            = 1'b1;
        end
      end
    end
    if (wr_en && ioctl_index == IOCTL_IDX_W'(MOD_INDEX) && ioctl_addr == '0) begin
      mod_shadow_d = ioctl_dout;
      mod_dirty_d  = 1'b1;
    end
    if (dl_fall) begin
      if (dip_dirty_q) begin
        dip_d       = dip_shadow_q;
        dip_valid_d = 1'b1;
        dip_dirty_d = 1'b0;
      end
      if (mod_dirty_q) begin
        mod_d       = mod_shadow_q;
        mod_valid_d = 1'b1;
        mod_dirty_d = 1'b0;
      end
    end
  end

  always_comb begin
    joy_d     = '0;
    joy_any_d = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      joy_d[p*JOY_W +: JOY_W] = db_ena[p] ? joy_db[p*JOY_W +: JOY_W] : joy_usb[p*JOY_W +: JOY_W];
      joy_any_d               = joy_any_d | joy_d[p*JOY_W +: JOY_W];
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      dip_shadow_q <= '0;
      mod_shadow_q <= '0;
      dip_dirty_q  <= 1'b0;
      mod_dirty_q  <= 1'b0;
      dip_q        <= '0;
      mod_q        <= '0;
      dip_valid_q  <= 1'b0;
      mod_valid_q  <= 1'b0;
      dl_q         <= 1'b0;
      joy_q        <= '0;
      joy_any_q    <= '0;
    end else begin
      dip_shadow_q <= dip_shadow_d;
      mod_shadow_q <= mod_shadow_d;
      dip_dirty_q  <= dip_dirty_d;
      mod_dirty_q  <= mod_dirty_d;
      dip_q        <= dip_d;
      mod_q        <= mod_d;
      dip_valid_q  <= dip_valid_d;
      mod_valid_q  <= mod_valid_d;
      dl_q         <= ioctl_download;
      joy_q        <= joy_d;
      joy_any_q    <= joy_any_d;
    end
  end

  assign dip       = dip_q;
  assign dip_valid = dip_valid_q;
  assign mod       = mod_q;
  assign mod_valid = mod_valid_q;
  assign joy_out   = joy_q;
  assign joy_any   = joy_any_q;

  for (genvar c = 0; c < int'(NUM_COINS); c++) begin : g_coin
    coin_shaper #(
      .COIN_PULSE (COIN_PULSE),
      .COIN_GAP   (COIN_GAP)
    ) u_coin (
      .clk_sys  (clk_sys),
      .RESET_L  (RESET_L),
      .tick     (tick),
      .coin_raw (coin_raw[c]),
      .coin_out (coin_out[c])
    );
  end
endmodule

// File: tb/tb_arcade_cfg_inputs.sv
// Directed bench for arcade_cfg_inputs: DIP/MOD shadow commit, reset, joystick mux, coin shaping.
module tb_arcade_cfg_inputs;
  localparam int unsigned NP = 2;
  localparam int unsigned NB = 8;
  localparam int unsigned NC = 2;
  localparam int COIN_PULSE = 4;
  localparam int COIN_GAP   = 4;

  logic          clk_sys, RESET_L;
  logic          ioctl_download, ioctl_wr;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          tick;
  logic [31:0]   joy_usb, joy_db;
  logic [NP-1:0] db_ena;
  logic [NC-1:0] coin_raw;
  logic [7:0]    mod;
  logic          mod_valid;
  logic [63:0]   dip;
  logic          dip_valid;
  logic [31:0]   joy_out;
  logic [15:0]   joy_any;
  logic [NC-1:0] coin_out;

  int checks   = 0;
  int failures = 0;

  arcade_cfg_inputs #(
    .NUM_PLAYERS(NP), .NUM_DIP_BANKS(NB), .DIP_INDEX(254), .MOD_INDEX(1),
    .NUM_COINS(NC), .COIN_PULSE(COIN_PULSE), .COIN_GAP(COIN_GAP)
  ) dut (
    .clk_sys(clk_sys), .RESET_L(RESET_L), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .tick(tick),
    .joy_usb(joy_usb), .joy_db(joy_db), .db_ena(db_ena), .coin_raw(coin_raw),
    .mod(mod), .mod_valid(mod_valid), .dip(dip), .dip_valid(dip_valid),
    .joy_out(joy_out), .joy_any(joy_any), .coin_out(coin_out)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Coin timing enable: one cycle high every 10 clocks.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (9) @(posedge clk_sys);
      #1 tick = 1'b1;
      @(posedge clk_sys);
      #1 tick = 1'b0;
    end
  end

  task automatic step;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
    ioctl_index = idx; ioctl_addr = addr; ioctl_dout = d; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic end_dl;
    ioctl_download = 1'b0;
    step();
  endtask

  // Drives n_rises coin presses on channel 0 and measures the shaped output over a fixed window.
  task automatic coin_run(input int n_rises, input int cycles, output int pulses, output int falls,
                          output int hi_bad, output int gap_bad, output int last_lo, output int ch1_hi);
    int hi_t, lo_t;
    logic prev;
    pulses = 0; falls = 0; hi_bad = 0; gap_bad = 0; ch1_hi = 0; hi_t = 0; lo_t = 0; prev = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      coin_raw = (i < 2*n_rises && (i % 2) == 0) ? 2'b01 : 2'b00;
      @(negedge clk_sys);
      if (coin_out[0] && !prev) begin
        if (pulses > 0 && lo_t < COIN_GAP) gap_bad++;
        pulses++;
        hi_t = 0;
      end
      if (!coin_out[0] && prev) begin
        if (hi_t != COIN_PULSE) hi_bad++;
        falls++;
        lo_t = 0;
      end
      if (tick) begin
        if (coin_out[0]) hi_t++;
        else lo_t++;
      end
      if (coin_out[1]) ch1_hi++;
      prev = coin_out[0];
      @(posedge clk_sys);
      #1;
    end
    coin_raw = '0;
    last_lo = lo_t;
  endtask

  task automatic test_reset;
    RESET_L = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0;
    ioctl_dout = '0; joy_usb = 32'h1234_5678; joy_db = 32'h9ABC_DEF0; db_ena = 2'b01; coin_raw = '0;
    step(); step();
    checks++; if (dip !== 64'h0) begin failures++; $display("FAIL reset_dip got=%h exp=0", dip); end
    checks++; if (dip_valid !== 1'b0) begin failures++; $display("FAIL reset_dip_valid got=%b exp=0", dip_valid); end
    checks++; if (mod !== 8'h0 || mod_valid !== 1'b0) begin failures++; $display("FAIL reset_mod got=%h/%b exp=0/0", mod, mod_valid); end
    checks++; if (joy_out !== 32'h0 || joy_any !== 16'h0) begin failures++; $display("FAIL reset_joy got=%h/%h exp=0/0", joy_out, joy_any); end
    checks++; if (coin_out !== 2'b00) begin failures++; $display("FAIL reset_coin got=%b exp=00", coin_out); end
    RESET_L = 1'b1; joy_usb = '0; joy_db = '0; db_ena = '0;
    step();
  endtask

  task automatic test_joy;
    db_ena = 2'b01; joy_usb = {16'h0200, 16'hAAAA}; joy_db = {16'h5555, 16'h0010};
    #1;
    checks++; if (joy_out !== 32'h0) begin failures++; $display("FAIL joy_latency got=%h exp=0", joy_out); end
    step();
    checks++; if (joy_out !== 32'h0200_0010) begin failures++; $display("FAIL joy_mux01 got=%h exp=02000010", joy_out); end
    checks++; if (joy_any !== 16'h0210) begin failures++; $display("FAIL joy_any01 got=%h exp=0210", joy_any); end
    db_ena = 2'b10;
    step();
    checks++; if (joy_out !== 32'h5555_AAAA || joy_any !== 16'hFFFF) begin
      failures++; $display("FAIL joy_mux10 got=%h/%h exp=5555aaaa/ffff", joy_out, joy_any); end
    db_ena = '0; joy_usb = '0; joy_db = '0;
    step();
  endtask

  task automatic test_dip_commit;
    start_dl();
    for (int b = 0; b < 8; b++) wr_byte(8'd254, 25'(b), 8'(17 * (b + 1)));
    checks++; if (dip !== 64'h0 || dip_valid !== 1'b0) begin
      failures++; $display("FAIL dip_precommit got=%h/%b exp=0/0", dip, dip_valid); end
    end_dl();
    checks++; if (dip !== 64'h8877_6655_4433_2211) begin failures++; $display("FAIL dip_commit got=%h exp=8877665544332211", dip); end
    checks++; if (dip_valid !== 1'b1) begin failures++; $display("FAIL dip_commit_valid got=%b exp=1", dip_valid); end
    checks++; if (mod_valid !== 1'b0) begin failures++; $display("FAIL dip_commit_mod_valid got=%b exp=0", mod_valid); end
  endtask

  task automatic test_dip_ignore;
    wr_byte(8'd254, 25'd0, 8'hEE);
    start_dl();
    wr_byte(8'd254, 25'd8, 8'hAA);
    wr_byte(8'd254, 25'd9, 8'hBB);
    wr_byte(8'd254, 25'd2, 8'h5A);
    wr_byte(8'd254, 25'h100, 8'hCC);
    end_dl();
    checks++; if (dip !== 64'h8877_6655_445A_2211) begin failures++; $display("FAIL dip_oob got=%h exp=88776655445a2211", dip); end
    start_dl();
    wr_byte(8'd3, 25'd0, 8'hFF);
    wr_byte(8'd3, 25'd1, 8'hFE);
    end_dl(); step();
    checks++; if (dip !== 64'h8877_6655_445A_2211 || dip_valid !== 1'b1) begin
      failures++; $display("FAIL other_index_dip got=%h/%b exp=88776655445a2211/1", dip, dip_valid); end
    checks++; if (mod !== 8'h0 || mod_valid !== 1'b0) begin failures++; $display("FAIL other_index_mod got=%h/%b exp=0/0", mod, mod_valid); end
    start_dl();
    wr_byte(8'd1, 25'd0, 8'h42);
    wr_byte(8'd1, 25'd1, 8'h99);
    checks++; if (mod !== 8'h0) begin failures++; $display("FAIL mod_precommit got=%h exp=0", mod); end
    end_dl();
    checks++; if (mod !== 8'h42 || mod_valid !== 1'b1) begin failures++; $display("FAIL mod_commit got=%h/%b exp=42/1", mod, mod_valid); end
    checks++; if (dip !== 64'h8877_6655_445A_2211) begin failures++; $display("FAIL mod_commit_dip got=%h exp=88776655445a2211", dip); end
  endtask

  task automatic test_reset_mid;
    start_dl();
    wr_byte(8'd254, 25'd0, 8'hA1);
    wr_byte(8'd254, 25'd1, 8'hA2);
    wr_byte(8'd254, 25'd2, 8'hA3);
    RESET_L = 1'b0;
    #1;
    checks++; if (dip !== 64'h0 || dip_valid !== 1'b0) begin failures++; $display("FAIL midreset_async got=%h/%b exp=0/0", dip, dip_valid); end
    checks++; if (mod !== 8'h0 || mod_valid !== 1'b0) begin failures++; $display("FAIL midreset_mod got=%h/%b exp=0/0", mod, mod_valid); end
    step();
    RESET_L = 1'b1;
    step();
    end_dl(); step();
    checks++; if (dip !== 64'h0 || dip_valid !== 1'b0) begin failures++; $display("FAIL midreset_nocommit got=%h/%b exp=0/0", dip, dip_valid); end
    start_dl();
    for (int b = 0; b < 8; b++) wr_byte(8'd254, 25'(b), 8'(b + 1));
    end_dl();
    checks++; if (dip !== 64'h0807_0605_0403_0201 || dip_valid !== 1'b1) begin
      failures++; $display("FAIL midreset_recommit got=%h/%b exp=0807060504030201/1", dip, dip_valid); end
  endtask

  task automatic test_coin_single;
    int pulses, falls, hi_bad, gap_bad, last_lo, ch1_hi;
    coin_run(1, 200, pulses, falls, hi_bad, gap_bad, last_lo, ch1_hi);
    checks++; if (pulses !== 1 || falls !== 1) begin failures++; $display("FAIL coin_single_count got=%0d/%0d exp=1/1", pulses, falls); end
    checks++; if (hi_bad !== 0) begin failures++; $display("FAIL coin_single_width bad=%0d exp=0", hi_bad); end
    checks++; if (last_lo < COIN_GAP) begin failures++; $display("FAIL coin_single_gap got=%0d exp>=%0d", last_lo, COIN_GAP); end
    checks++; if (ch1_hi !== 0) begin failures++; $display("FAIL coin_single_ch1 got=%0d exp=0", ch1_hi); end
  endtask

  task automatic test_coin_burst;
    int pulses, falls, hi_bad, gap_bad, last_lo, ch1_hi;
    coin_run(5, 450, pulses, falls, hi_bad, gap_bad, last_lo, ch1_hi);
    checks++; if (pulses !== 4 || falls !== 4) begin failures++; $display("FAIL coin_burst_count got=%0d/%0d exp=4/4", pulses, falls); end
    checks++; if (hi_bad !== 0) begin failures++; $display("FAIL coin_burst_width bad=%0d exp=0", hi_bad); end
    checks++; if (gap_bad !== 0) begin failures++; $display("FAIL coin_burst_gap bad=%0d exp=0", gap_bad); end
    checks++; if (last_lo < COIN_GAP || coin_out !== 2'b00) begin
      failures++; $display("FAIL coin_burst_tail got=%0d/%b exp>=%0d/00", last_lo, coin_out, COIN_GAP); end
  endtask

  initial begin
    test_reset();
    test_joy();
    test_dip_commit();
    test_dip_ignore();
    test_reset_mid();
    test_coin_single();
    test_coin_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
